// File: rtl/alu_op_decoder.sv
// RISC-V opcode/funct3/funct7 -> ALU operation decoder behind a registered 2-entry FIFO.
// Optional statistics counters enabled by defining ALU_OP_DECODER_STATS_EN.
module alu_op_decoder #(
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     illegal
`ifdef ALU_OP_DECODER_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]     decoded_cnt,
   output logic [CNT_WIDTH-1:0]     illegal_cnt
`endif
);

   if (OPCODE_LENGTH < 4 || CNT_WIDTH < 1) begin : g_bad_params
      $error("alu_op_decoder: OPCODE_LENGTH must be >= 4 and CNT_WIDTH >= 1");
   end

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_XOR = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0100;
   localparam logic [3:0] ALU_BEQ = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_LUI = 4'b1010;
   localparam logic [3:0] ALU_SRL = 4'b1100;
   localparam logic [3:0] ALU_SLT = 4'b1110;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   typedef struct packed {
      logic [OPCODE_LENGTH-1:0] op;
      logic                     ill;
   } entry_t;

   logic [3:0] dec_op;
   entry_t     dec_entry;

   // 1111 is never a legal result, so illegal is derived from it
   always_comb begin
      dec_op = ALU_ILL;
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  dec_op = ALU_ADD;
                  3'b111:  dec_op = ALU_AND;
                  3'b110:  dec_op = ALU_OR;
                  3'b100:  dec_op = ALU_XOR;
                  3'b010:  dec_op = ALU_SLT;
                  3'b001:  dec_op = ALU_SLL;
                  3'b101:  dec_op = ALU_SRL;
                  default: dec_op = ALU_ILL;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_op = ALU_SUB;
            end
         end
         7'b0010011: begin
            case (funct3)
               3'b000:  dec_op = ALU_ADD;
               3'b111:  dec_op = ALU_AND;
               3'b110:  dec_op = ALU_OR;
               3'b100:  dec_op = ALU_XOR;
               3'b010:  dec_op = ALU_SLT;
               3'b001:  if (funct7 == 7'b0000000) dec_op = ALU_SLL;
               3'b101:  if (funct7 == 7'b0000000) dec_op = ALU_SRL;
               default: dec_op = ALU_ILL;
            endcase
         end
         7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111: dec_op = ALU_ADD;
         7'b1100011: if (funct3 == 3'b000) dec_op = ALU_BEQ;
         7'b0110111: dec_op = ALU_LUI;
         default:    dec_op = ALU_ILL;
      endcase
      dec_entry.op  = OPCODE_LENGTH'(dec_op);
      dec_entry.ill = (dec_op == ALU_ILL);
   end

   entry_t     mem [2];
   entry_t     head;
   logic       wptr, rptr;
   logic [1:0] count;
   logic       push, pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign Operation = head.op;
   assign illegal   = head.ill;

   // head is a dedicated register so outputs stay put while the FIFO is empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= 2'd0;
         wptr   <= 1'b0;
         rptr   <= 1'b0;
         head   <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= dec_entry;
            wptr      <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         count <= count + 2'(push) - 2'(pop);
         if (pop && count == 2'd2)
            head <= mem[~rptr];
         else if (push && (count == 2'd0 || (pop && count == 2'd1)))
            head <= dec_entry;
      end
   end

`ifdef ALU_OP_DECODER_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         decoded_cnt <= '0;
         illegal_cnt <= '0;
      end else if (push) begin
         if (decoded_cnt != '1) decoded_cnt <= decoded_cnt + CNT_WIDTH'(1);
         if (dec_entry.ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: table-driven reference decode, queue-based FIFO model.
module tb_alu_op_decoder;

   localparam int OPW   = 4;
   localparam int CNT_W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid, in_ready, out_valid, out_ready, illegal;
   logic [6:0]     opcode, funct7;
   logic [2:0]     funct3;
   logic [OPW-1:0] Operation;
`ifdef ALU_OP_DECODER_STATS_EN
   logic [CNT_W-1:0] decoded_cnt, illegal_cnt;
`endif

   always #5 clk = ~clk;

   alu_op_decoder #(.OPCODE_LENGTH(OPW), .CNT_WIDTH(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .out_valid(out_valid), .out_ready(out_ready),
      .Operation(Operation), .illegal(illegal)
`ifdef ALU_OP_DECODER_STATS_EN
      , .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
`endif
   );

   typedef struct {
      bit [6:0] opc;
      bit       chk3;
      bit [2:0] f3;
      bit       chk7;
      bit [6:0] f7;
      bit [3:0] op;
   } rule_t;

   typedef struct {
      logic [3:0] op;
      logic       ill;
   } exp_t;

   rule_t rules[$];
   exp_t  exp_q[$];
   int    n_vec = 0, n_err = 0;
   int    exp_dec = 0, exp_ill = 0;
   bit [6:0] opc_pool[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // list of legal encodings; anything not matched is illegal
   function automatic exp_t ref_decode(input bit [6:0] o, input bit [2:0] f3, input bit [6:0] f7);
      exp_t r;
      r.op  = 4'b1111;
      r.ill = 1'b1;
      foreach (rules[i])
         if (rules[i].opc == o && (!rules[i].chk3 || rules[i].f3 == f3) &&
             (!rules[i].chk7 || rules[i].f7 == f7)) begin
            r.op  = rules[i].op;
            r.ill = 1'b0;
         end
      return r;
   endfunction

   task automatic add_rule(input bit [6:0] o, input bit c3, input bit [2:0] f3,
                           input bit c7, input bit [6:0] f7, input bit [3:0] op);
      rule_t r;
      r.opc = o; r.chk3 = c3; r.f3 = f3; r.chk7 = c7; r.f7 = f7; r.op = op;
      rules.push_back(r);
   endtask

   task automatic drive(input bit v, input bit [6:0] o, input bit [2:0] f3,
                        input bit [6:0] f7, input bit rdy);
      in_valid = v; opcode = o; funct3 = f3; funct7 = f7; out_ready = rdy;
      @(posedge clk); #1;
   endtask

   // issue side: records the expected result of every input handshake
   always @(negedge clk) begin
      #1;
      if (!reset && in_valid && in_ready) begin
         exp_t e;
         e = ref_decode(opcode, funct3, funct7);
         exp_q.push_back(e);
         if (exp_dec < (1 << CNT_W) - 1) exp_dec++;
         if (e.ill && exp_ill < (1 << CNT_W) - 1) exp_ill++;
      end
   end

   // monitor side: checks handshake signals against model occupancy and pops on output handshakes
   always @(negedge clk) begin
      if (!reset) begin
         check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
         if (out_valid && out_ready && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("Operation", 32'(Operation), 32'(e.op));
            check("illegal", 32'(illegal), 32'(e.ill));
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0; out_ready = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      exp_dec = 0; exp_ill = 0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst Operation", 32'(Operation), 32'd0);
      check("rst illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
      foreach (opc_pool[i]) opc_pool[i] = 7'b0;
      opc_pool = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0000011,
                   7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
      add_rule(7'b0110011, 1, 3'b000, 1, 7'h00, 4'b0100);
      add_rule(7'b0110011, 1, 3'b000, 1, 7'h20, 4'b0010);
      add_rule(7'b0110011, 1, 3'b111, 1, 7'h00, 4'b0000);
      add_rule(7'b0110011, 1, 3'b110, 1, 7'h00, 4'b0011);
      add_rule(7'b0110011, 1, 3'b100, 1, 7'h00, 4'b0001);
      add_rule(7'b0110011, 1, 3'b010, 1, 7'h00, 4'b1110);
      add_rule(7'b0110011, 1, 3'b001, 1, 7'h00, 4'b1001);
      add_rule(7'b0110011, 1, 3'b101, 1, 7'h00, 4'b1100);
      add_rule(7'b0010011, 1, 3'b000, 0, 7'h00, 4'b0100);
      add_rule(7'b0010011, 1, 3'b111, 0, 7'h00, 4'b0000);
      add_rule(7'b0010011, 1, 3'b110, 0, 7'h00, 4'b0011);
      add_rule(7'b0010011, 1, 3'b100, 0, 7'h00, 4'b0001);
      add_rule(7'b0010011, 1, 3'b010, 0, 7'h00, 4'b1110);
      add_rule(7'b0010011, 1, 3'b001, 1, 7'h00, 4'b1001);
      add_rule(7'b0010011, 1, 3'b101, 1, 7'h00, 4'b1100);
      add_rule(7'b0000011, 0, 3'b000, 0, 7'h00, 4'b0100);
      add_rule(7'b0100011, 0, 3'b000, 0, 7'h00, 4'b0100);
      add_rule(7'b1101111, 0, 3'b000, 0, 7'h00, 4'b0100);
      add_rule(7'b1100111, 0, 3'b000, 0, 7'h00, 4'b0100);
      add_rule(7'b1100011, 1, 3'b000, 0, 7'h00, 4'b1000);
      add_rule(7'b0110111, 0, 3'b000, 0, 7'h00, 4'b1010);

      @(posedge clk); #1;
      do_reset();

      // back-to-back R-type stream
      drive(1, 7'b0110011, 3'b000, 7'h00, 1);
      drive(1, 7'b0110011, 3'b000, 7'h20, 1);
      drive(1, 7'b0110011, 3'b010, 7'h00, 1);
      drive(1, 7'b0110011, 3'b101, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);

      // boundary decodes
      drive(1, 7'b0110111, 3'b011, 7'h13, 1);
      drive(1, 7'b1100011, 3'b000, 7'h00, 1);
      drive(1, 7'b1100011, 3'b001, 7'h00, 1);
      drive(1, 7'b0000011, 3'b010, 7'h00, 1);
      drive(1, 7'b0010011, 3'b001, 7'h20, 1);
      drive(1, 7'b0110011, 3'b011, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);

      // fill while stalled, then drain; third waits for a freed slot
      drive(1, 7'b0110011, 3'b111, 7'h00, 0);
      drive(1, 7'b0110011, 3'b110, 7'h00, 0);
      drive(1, 7'b0110011, 3'b100, 7'h00, 0);
      check("full in_ready", 32'(in_ready), 32'd0);
      drive(1, 7'b0110011, 3'b100, 7'h00, 1);
      drive(1, 7'b0110011, 3'b100, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);

      // reset with two entries buffered
      drive(1, 7'b0010011, 3'b000, 7'h00, 0);
      drive(1, 7'b0010011, 3'b111, 7'h00, 0);
      check("pre-reset full", 32'(in_ready), 32'd0);
      do_reset();
      drive(1, 7'b0110111, 3'b000, 7'h00, 0);
      drive(0, 7'b0, 3'b0, 7'h00, 0);
      drive(0, 7'b0, 3'b0, 7'h00, 1);
      drive(0, 7'b0, 3'b0, 7'h00, 1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit [6:0] o, f7;
         int sel;
         o   = ($urandom_range(0, 4) != 0) ? opc_pool[$urandom_range(0, 9)] : 7'($urandom);
         sel = $urandom_range(0, 9);
         f7  = (sel < 6) ? 7'h00 : (sel < 8) ? 7'h20 : 7'($urandom);
         drive($urandom_range(0, 3) != 0, o, 3'($urandom), f7, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(0, 7'b0, 3'b0, 7'h00, 1);
      check("drain empty", 32'(exp_q.size()), 32'd0);

      // counter saturation: 20 accepted inputs, 3 illegal, with stalls in between
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i == 4 || i == 9 || i == 15) drive(1, 7'b1111111, 3'b000, 7'h00, 0);
         else drive(1, 7'b0110011, 3'b000, 7'h00, 0);
         while (!in_ready) drive(1, 7'b0110011, 3'b000, 7'h00, 1);
      end
      drive(0, 7'b0, 3'b0, 7'h00, 1);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(0, 7'b0, 3'b0, 7'h00, 1);
      check("drain empty 2", 32'(exp_q.size()), 32'd0);
`ifdef ALU_OP_DECODER_STATS_EN
      check("decoded_cnt", 32'(decoded_cnt), 32'(exp_dec));
      check("illegal_cnt", 32'(illegal_cnt), 32'(exp_ill));
      check("decoded_cnt sat", 32'(decoded_cnt), 32'd15);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Producer side of the ALU `Operation` interface: decodes RISC-V instruction fields (opcode, funct3, funct7) into the 4-bit ALU operation code consumed by the ALU.
- Sits between instruction decode and execute.
- Registered, order-preserving, 2-entry buffer with valid/ready on both sides.
- Flags unsupported encodings as illegal.

Parameters:
- OPCODE_LENGTH, 4, width of the ALU operation code output
- CNT_WIDTH, 16, width of the statistics counters (used only with the optional feature)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  instruction fields present
- in_ready  out  1  decoder can accept this cycle
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- out_valid  out  1  Operation/illegal valid
- out_ready  in  1  consumer accepts this cycle
- Operation  out  OPCODE_LENGTH  ALU operation code
- illegal  out  1  head entry is an unsupported encoding

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready at a clock edge.
  - Output transfer when out_valid && out_ready at a clock edge.
- Decode is combinational on the input fields. The result {Operation, illegal} is written into the buffer on an input transfer.
- Decode table, by opcode:
  - 0110011 (R-type), funct3 / funct7:
    - 000 / 0000000 → 0100 (ADD)
    - 000 / 0100000 → 0010 (SUB)
    - 111 / 0000000 → 0000 (AND)
    - 110 / 0000000 → 0011 (OR)
    - 100 / 0000000 → 0001 (XOR)
    - 010 / 0000000 → 1110 (SLT)
    - 001 / 0000000 → 1001 (SLL)
    - 101 / 0000000 → 1100 (SRL)
  - 0010011 (I-type), funct3; funct7 ignored except for shifts:
    - 000 → 0100 (ADDI)
    - 111 → 0000 (ANDI)
    - 110 → 0011 (ORI)
    - 100 → 0001 (XORI)
    - 010 → 1110 (SLTI)
    - 001 with funct7=0000000 → 1001 (SLLI)
    - 101 with funct7=0000000 → 1100 (SRLI)
  - 0000011 (load), 0100011 (store), 1101111 (JAL), 1100111 (JALR) → 0100
  - 1100011 (branch) with funct3=000 → 1000 (BEQ equal)
  - 0110111 (LUI) → 1010
  - Any other combination → Operation=1111, illegal=1. Otherwise illegal=0.
- Buffer:
  - 2-entry FIFO; `count` in {0,1,2}.
  - in_ready = (count != 2); out_valid = (count != 0).
  - Outputs always show the head entry, and are driven from registers only.
- Latency: an input accepted at edge N is visible on the outputs in the cycle after edge N, when the buffer was empty at edge N.
- Throughput: 1 per cycle while out_ready is held high.
- Boundary conditions:
  - Empty: out_valid=0; Operation/illegal hold the last head value (don't-care to consumers).
  - Full (count=2): in_ready=0; input is ignored even if in_valid=1. A pop at that edge leaves count=1; the freed slot is accepted only on the next cycle.
  - count=1 with simultaneous push and pop: count stays 1; the new entry becomes head next cycle.
  - count=0 with push: count becomes 1. A pop is impossible because out_valid=0.
  - Read/write pointers wrap modulo 2.
- Reset, including mid-operation:
  - count=0, pointers=0, out_valid=0, in_ready=1, Operation=0000, illegal=0.
  - In-flight entries are discarded.
- Outputs have no combinational path from any input, including out_ready. in_ready depends only on `count`.

Optional Feature:
- Macro: ALU_OP_DECODER_STATS_EN
- Defined:
  - Adds output ports decoded_cnt [CNT_WIDTH] and illegal_cnt [CNT_WIDTH].
  - decoded_cnt increments on every input transfer; illegal_cnt increments on input transfers whose decode is illegal.
  - Both saturate at all-ones, reset to 0, and are registered.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset asserted mid-stream with 2 entries buffered → same cycle: out_valid=0, in_ready=1, Operation=0000, illegal=0; after release, the first new input appears alone.
- Stream with out_ready=1 of R-type ADD(000/0000000), SUB(000/0100000), SLT(010), SRL(101/0000000), one per cycle → outputs 0100, 0010, 1110, 1100 on consecutive cycles, 1-cycle latency, illegal=0.
- opcode 0110111 → 1010; 1100011/funct3=000 → 1000; 1100011/funct3=001 → 1111 with illegal=1; 0000011 → 0100; 0010011/001/funct7=0100000 → illegal=1.
- out_ready=0, push 3 consecutive instructions → first two accepted, in_ready=0 on third cycle; raise out_ready → entries exit in order, third accepted only after a slot frees.
- count=1, in_valid=1 and out_ready=1 same edge → count stays 1, out_valid stays 1, new entry is head next cycle.
- With ALU_OP_DECODER_STATS_EN, CNT_WIDTH=4: 20 accepted inputs, 3 illegal → decoded_cnt=15 (saturated), illegal_cnt=3; stalled (in_ready=0) inputs are not counted.
